// File: rtl/pulpino_chan_pkg.sv
// Shared constants for the PULPino-to-USB byte channel and the status word
// that the register file builds from its flags.
package pulpino_chan_pkg;

    localparam int DEF_DEPTH      = 16;
    localparam int DEF_DATA_WIDTH = 8;

    localparam int STAT_EMPTY_BIT     = 0;
    localparam int STAT_FULL_BIT      = 1;
    localparam int STAT_UNDERFLOW_BIT = 2;

    // One extra bit so a full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchroniser for a level-toggle signal, followed by an edge
// detector that emits a registered one-cycle event per level change.
module toggle_sync (
    input  logic clk,
    input  logic reset_i,
    input  logic toggle_i,
    output logic event_o
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_event;

    // Reset loads the raw input so a toggle held high through reset is not an event.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_s1    <= toggle_i;
            r_s2    <= toggle_i;
            r_s3    <= toggle_i;
            r_event <= 1'b0;
        end else begin
            r_s1    <= toggle_i;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_event <= r_s2 ^ r_s3;
        end
    end

    assign event_o = r_event;

endmodule

// File: rtl/pulpino_to_usb_fifo.sv
// Byte FIFO from PULPino firmware (toggle/ack handshake) to the USB register
// file (synchronised pop toggle), with sticky underflow and a flush pulse.
module pulpino_to_usb_fifo
    import pulpino_chan_pkg::*;
#(
    parameter int pDEPTH      = DEF_DEPTH,
    parameter int pDATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic [pDATA_WIDTH-1:0]   pulpino_data_i,
    input  logic                     pulpino_write_toggle_i,
    output logic                     pulpino_ack_toggle_o,
    input  logic                     usb_pop_toggle_i,
    input  logic                     clear_i,
    output logic [pDATA_WIDTH-1:0]   usb_head_o,
    output logic [$clog2(pDEPTH):0]  usb_count_o,
    output logic                     usb_empty_o,
    output logic                     usb_full_o,
    output logic                     underflow_o
);

    localparam int PTR_W = $clog2(pDEPTH);
    localparam int CNT_W = cnt_w(pDEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(pDEPTH);

    logic [pDATA_WIDTH-1:0] r_mem [pDEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic [pDATA_WIDTH-1:0] r_pend_data;
    logic                   r_pending;
    logic                   r_wr_tog_q;
    logic                   r_ack;
    logic                   r_underflow;

    logic w_pop_evt;
    logic w_wr_edge;
    logic w_push;
    logic w_pop_ok;

    toggle_sync u_pop_sync (
        .clk      (clk),
        .reset_i  (reset_i),
        .toggle_i (usb_pop_toggle_i),
        .event_o  (w_pop_evt)
    );

    // A full FIFO still accepts the pending byte when a pop frees a slot this cycle.
    always_comb begin
        w_wr_edge = pulpino_write_toggle_i ^ r_wr_tog_q;
        w_pop_ok  = w_pop_evt && !clear_i && !reset_i && (r_count != '0);
        w_push    = r_pending && !clear_i && !reset_i &&
                    ((r_count != DEPTH_C) || w_pop_evt);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_pend_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_pend_data <= '0;
            r_pending   <= 1'b0;
            r_wr_tog_q  <= pulpino_write_toggle_i;
            r_ack       <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_tog_q <= pulpino_write_toggle_i;
            if (clear_i) begin
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_count     <= '0;
                r_underflow <= 1'b0;
                // Dropped byte is still acknowledged so firmware never stalls.
                if (r_pending) begin
                    r_pending <= 1'b0;
                    r_ack     <= ~r_ack;
                end else if (w_wr_edge) begin
                    r_pending   <= 1'b1;
                    r_pend_data <= pulpino_data_i;
                end
            end else begin
                if (w_push) begin
                    r_wptr    <= r_wptr + PTR_W'(1);
                    r_pending <= 1'b0;
                    r_ack     <= ~r_ack;
                end else if (!r_pending && w_wr_edge) begin
                    r_pending   <= 1'b1;
                    r_pend_data <= pulpino_data_i;
                end
                if (w_pop_ok) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (w_pop_evt && (r_count == '0)) begin
                    r_underflow <= 1'b1;
                end
                case ({w_push, w_pop_ok})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign pulpino_ack_toggle_o = r_ack;
    assign usb_count_o          = r_count;
    assign usb_empty_o          = (r_count == '0);
    assign usb_full_o           = (r_count == DEPTH_C);
    assign underflow_o          = r_underflow;
    assign usb_head_o           = (r_count == '0) ? '0 : r_mem[r_rptr];

endmodule

// File: tb/tb_pulpino_to_usb_fifo.sv
// Directed bench for pulpino_to_usb_fifo at depth 16, byte width 8.
module tb_pulpino_to_usb_fifo;

    logic       clk;
    logic       reset_i;
    logic [7:0] pulpino_data_i;
    logic       pulpino_write_toggle_i;
    logic       pulpino_ack_toggle_o;
    logic       usb_pop_toggle_i;
    logic       clear_i;
    logic [7:0] usb_head_o;
    logic [4:0] usb_count_o;
    logic       usb_empty_o;
    logic       usb_full_o;
    logic       underflow_o;

    int n_pass  = 0;
    int n_total = 0;
    logic exp_ack = 1'b0;

    pulpino_to_usb_fifo #(.pDEPTH(16), .pDATA_WIDTH(8)) dut (
        .clk                    (clk),
        .reset_i                (reset_i),
        .pulpino_data_i         (pulpino_data_i),
        .pulpino_write_toggle_i (pulpino_write_toggle_i),
        .pulpino_ack_toggle_o   (pulpino_ack_toggle_o),
        .usb_pop_toggle_i       (usb_pop_toggle_i),
        .clear_i                (clear_i),
        .usb_head_o             (usb_head_o),
        .usb_count_o            (usb_count_o),
        .usb_empty_o            (usb_empty_o),
        .usb_full_o             (usb_full_o),
        .underflow_o            (underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a byte; two edges later it is in the FIFO if there was room.
    task automatic write_byte(input logic [7:0] d);
        pulpino_data_i         = d;
        pulpino_write_toggle_i = ~pulpino_write_toggle_i;
        tick(2);
    endtask

    // Pop toggle needs four edges (sync, sync, detect, act) to take effect.
    task automatic pop_byte();
        usb_pop_toggle_i = ~usb_pop_toggle_i;
        tick(4);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick(3);
        reset_i = 1'b0;
        tick(1);
        exp_ack = 1'b0;
        n_total++;
        if (pulpino_ack_toggle_o !== 1'b0 || usb_count_o !== 5'd0 || usb_empty_o !== 1'b1 ||
            usb_full_o !== 1'b0 || usb_head_o !== 8'h00 || underflow_o !== 1'b0)
            $display("FAIL reset_state ack=%b cnt=%0d emp=%b full=%b head=%h unf=%b required 0 0 1 0 00 0",
                     pulpino_ack_toggle_o, usb_count_o, usb_empty_o, usb_full_o, usb_head_o, underflow_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        pulpino_data_i         = 8'hA5;
        pulpino_write_toggle_i = ~pulpino_write_toggle_i;
        tick(1);
        n_total++;
        if (usb_count_o !== 5'd0 || pulpino_ack_toggle_o !== exp_ack)
            $display("FAIL basic_latency_n cnt=%0d ack=%b required 0 %b", usb_count_o, pulpino_ack_toggle_o, exp_ack);
        else n_pass++;
        tick(1);
        exp_ack = ~exp_ack;
        n_total++;
        if (usb_count_o !== 5'd1 || pulpino_ack_toggle_o !== exp_ack || usb_head_o !== 8'hA5)
            $display("FAIL basic_wr1 cnt=%0d ack=%b head=%h required 1 %b a5", usb_count_o, pulpino_ack_toggle_o, usb_head_o, exp_ack);
        else n_pass++;
        write_byte(8'h3C);
        exp_ack = ~exp_ack;
        n_total++;
        if (usb_count_o !== 5'd2 || pulpino_ack_toggle_o !== exp_ack || usb_head_o !== 8'hA5)
            $display("FAIL basic_wr2 cnt=%0d ack=%b head=%h required 2 %b a5", usb_count_o, pulpino_ack_toggle_o, usb_head_o, exp_ack);
        else n_pass++;
        usb_pop_toggle_i = ~usb_pop_toggle_i;
        tick(3);
        n_total++;
        if (usb_count_o !== 5'd2)
            $display("FAIL basic_pop_latency cnt=%0d required 2", usb_count_o);
        else n_pass++;
        tick(1);
        n_total++;
        if (usb_count_o !== 5'd1 || usb_head_o !== 8'h3C)
            $display("FAIL basic_pop1 cnt=%0d head=%h required 1 3c", usb_count_o, usb_head_o);
        else n_pass++;
        pop_byte();
        n_total++;
        if (usb_count_o !== 5'd0 || usb_head_o !== 8'h00 || usb_empty_o !== 1'b1 || underflow_o !== 1'b0)
            $display("FAIL basic_pop2 cnt=%0d head=%h emp=%b unf=%b required 0 00 1 0",
                     usb_count_o, usb_head_o, usb_empty_o, underflow_o);
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(i));
            exp_ack = ~exp_ack;
        end
        n_total++;
        if (usb_count_o !== 5'd16 || usb_full_o !== 1'b1 || usb_head_o !== 8'h00 || pulpino_ack_toggle_o !== exp_ack)
            $display("FAIL fill_full cnt=%0d full=%b head=%h ack=%b required 16 1 00 %b",
                     usb_count_o, usb_full_o, usb_head_o, pulpino_ack_toggle_o, exp_ack);
        else n_pass++;
        write_byte(8'h10);
        tick(2);
        n_total++;
        if (pulpino_ack_toggle_o !== exp_ack || usb_count_o !== 5'd16)
            $display("FAIL fill_backpressure ack=%b cnt=%0d required %b 16", pulpino_ack_toggle_o, usb_count_o, exp_ack);
        else n_pass++;
        pop_byte();
        exp_ack = ~exp_ack;
        n_total++;
        if (pulpino_ack_toggle_o !== exp_ack || usb_count_o !== 5'd16 || usb_head_o !== 8'h01 || usb_full_o !== 1'b1)
            $display("FAIL fill_pop_push ack=%b cnt=%0d head=%h full=%b required %b 16 01 1",
                     pulpino_ack_toggle_o, usb_count_o, usb_head_o, usb_full_o, exp_ack);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (usb_head_o !== 8'(i + 1))
                $display("FAIL drain_head[%0d] head=%h required %h", i, usb_head_o, 8'(i + 1));
            else n_pass++;
            pop_byte();
        end
        n_total++;
        if (usb_count_o !== 5'd0 || usb_empty_o !== 1'b1 || underflow_o !== 1'b0)
            $display("FAIL drain_end cnt=%0d emp=%b unf=%b required 0 1 0", usb_count_o, usb_empty_o, underflow_o);
        else n_pass++;
    endtask

    task automatic test_underflow();
        pop_byte();
        n_total++;
        if (underflow_o !== 1'b1 || usb_count_o !== 5'd0)
            $display("FAIL underflow_set unf=%b cnt=%0d required 1 0", underflow_o, usb_count_o);
        else n_pass++;
        write_byte(8'h55);
        exp_ack = ~exp_ack;
        n_total++;
        if (underflow_o !== 1'b1 || usb_count_o !== 5'd1 || usb_head_o !== 8'h55)
            $display("FAIL underflow_sticky unf=%b cnt=%0d head=%h required 1 1 55", underflow_o, usb_count_o, usb_head_o);
        else n_pass++;
        pulse_clear();
        n_total++;
        if (underflow_o !== 1'b0 || usb_count_o !== 5'd0 || usb_empty_o !== 1'b1 || pulpino_ack_toggle_o !== exp_ack)
            $display("FAIL underflow_clear unf=%b cnt=%0d emp=%b ack=%b required 0 0 1 %b",
                     underflow_o, usb_count_o, usb_empty_o, pulpino_ack_toggle_o, exp_ack);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            write_byte(8'(8'h40 + i));
            exp_ack = ~exp_ack;
            n_total++;
            if (usb_head_o !== 8'(8'h40 + i) || usb_count_o !== 5'd1 || pulpino_ack_toggle_o !== exp_ack)
                $display("FAIL wrap_push[%0d] head=%h cnt=%0d ack=%b required %h 1 %b",
                         i, usb_head_o, usb_count_o, pulpino_ack_toggle_o, 8'(8'h40 + i), exp_ack);
            else n_pass++;
            pop_byte();
            n_total++;
            if (usb_count_o !== 5'd0 || underflow_o !== 1'b0)
                $display("FAIL wrap_pop[%0d] cnt=%0d unf=%b required 0 0", i, usb_count_o, underflow_o);
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(8'h20 + i));
            exp_ack = ~exp_ack;
        end
        write_byte(8'h77);
        n_total++;
        if (pulpino_ack_toggle_o !== exp_ack || usb_count_o !== 5'd16 || usb_head_o !== 8'h20)
            $display("FAIL clear_pending ack=%b cnt=%0d head=%h required %b 16 20",
                     pulpino_ack_toggle_o, usb_count_o, usb_head_o, exp_ack);
        else n_pass++;
        pulse_clear();
        exp_ack = ~exp_ack;
        n_total++;
        if (usb_count_o !== 5'd0 || usb_empty_o !== 1'b1 || pulpino_ack_toggle_o !== exp_ack || usb_head_o !== 8'h00)
            $display("FAIL clear_flush cnt=%0d emp=%b ack=%b head=%h required 0 1 %b 00",
                     usb_count_o, usb_empty_o, pulpino_ack_toggle_o, usb_head_o, exp_ack);
        else n_pass++;
        tick(5);
        n_total++;
        if (pulpino_ack_toggle_o !== exp_ack || usb_head_o !== 8'h00 || usb_count_o !== 5'd0)
            $display("FAIL clear_settled ack=%b head=%h cnt=%0d required %b 00 0",
                     pulpino_ack_toggle_o, usb_head_o, usb_count_o, exp_ack);
        else n_pass++;
    endtask

    task automatic test_reset_toggles_high();
        reset_i = 1'b1;
        tick(1);
        pulpino_write_toggle_i = 1'b1;
        usb_pop_toggle_i       = 1'b1;
        pulpino_data_i         = 8'hEE;
        tick(3);
        reset_i = 1'b0;
        exp_ack = 1'b0;
        tick(6);
        n_total++;
        if (pulpino_ack_toggle_o !== 1'b0 || usb_count_o !== 5'd0 || underflow_o !== 1'b0)
            $display("FAIL rst_high_quiet ack=%b cnt=%0d unf=%b required 0 0 0",
                     pulpino_ack_toggle_o, usb_count_o, underflow_o);
        else n_pass++;
        write_byte(8'h9A);
        exp_ack = ~exp_ack;
        n_total++;
        if (pulpino_ack_toggle_o !== exp_ack || usb_count_o !== 5'd1 || usb_head_o !== 8'h9A)
            $display("FAIL rst_high_write ack=%b cnt=%0d head=%h required %b 1 9a",
                     pulpino_ack_toggle_o, usb_count_o, usb_head_o, exp_ack);
        else n_pass++;
        pop_byte();
        n_total++;
        if (usb_count_o !== 5'd0 || underflow_o !== 1'b0 || usb_head_o !== 8'h00)
            $display("FAIL rst_high_pop cnt=%0d unf=%b head=%h required 0 0 00", usb_count_o, underflow_o, usb_head_o);
        else n_pass++;
    endtask

    initial begin
        reset_i                = 1'b1;
        pulpino_data_i         = 8'h00;
        pulpino_write_toggle_i = 1'b0;
        usb_pop_toggle_i       = 1'b0;
        clear_i                = 1'b0;
        test_reset();
        test_basic();
        test_fill();
        test_underflow();
        test_wrap();
        test_clear();
        test_reset_toggles_high();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
